// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : PC sequencer with req/ack instruction fetch; presents one
//                instruction until the control unit commits it with PCen.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int              SIZE     = 64,
    parameter logic [SIZE-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrc,
    input  logic            PCen,
    input  logic [SIZE-1:0] branch_target,
    input  logic            imem_ack,
    input  logic [SIZE-1:0] imem_rdata,
    output logic            imem_req,
    output logic [SIZE-1:0] imem_addr,
    output logic [SIZE-1:0] inst,
    output logic            inst_valid,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] pc_plus4,
    output logic            align_err
);

    localparam logic [SIZE-1:0] c_step = SIZE'(PC_STEP);

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_req;
    logic [SIZE-1:0] r_pc;
    logic [SIZE-1:0] r_inst;
    logic            r_inst_valid;
    logic            r_align_err;

    logic [SIZE-1:0] w_pc_seq;
    logic [SIZE-1:0] w_pc_branch;
    logic            w_misaligned;

    assign w_pc_seq     = r_pc + c_step;
    assign w_pc_branch  = {branch_target[SIZE-1:2], 2'b00};
    assign w_misaligned = |branch_target[1:0];

    // imem_req is a register so it reads 0 throughout reset and rises on the
    // first clock edge after release; an ack only counts while it is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            r_align_err <= 1'b0;
            case (r_state)
                S_REQ: begin
                    if (r_req && imem_ack) begin
                        r_inst       <= imem_rdata;
                        r_inst_valid <= 1'b1;
                        r_req        <= 1'b0;
                        r_state      <= S_HOLD;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (PCen) begin
                        r_pc         <= PCSrc ? w_pc_branch : w_pc_seq;
                        r_align_err  <= PCSrc && w_misaligned;
                        r_inst_valid <= 1'b0;
                        r_req        <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_valid = r_inst_valid;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_seq;
    assign align_err  = r_align_err;

endmodule
`default_nettype wire
